noc_router_rr: RTL and testbench

Parametrised five-port mesh NoC router: a successor to the fixed-coordinate router, generalised in flit width, coordinate width and input buffer depth, with per-input FIFOs, valid/ready backpressure on every port and round-robin output arbitration. One instance sits at each mesh node at coordinate (XCOORD, YCOORD). Each instance routes single-flit packets dimension-order (X then Y) to its North, South, East, West and Local neighbours.

---
 rtl/noc_router_rr.sv | 188 ++++++++++++++++++
 tb/tb_noc_router_rr.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/noc_router_rr.sv
// noc_router_rr -- five-port mesh NoC router with per-input FIFOs, dimension-order (X then Y)
// routing of single-flit packets and an independent round-robin arbiter per output.
//
// Port index mapping for every 5-bit vector and every packed data bus: 0=N, 1=S, 2=E, 3=W, 4=L.
//   clk        single clock, all state updates on the rising edge
//   rst        synchronous, active-high reset; discards every buffered flit
//   in_valid   per-input flit valid
//   in_data    per-input flit, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   in_ready   input FIFO p has room (low while rst is high)
//   out_valid  output register p holds a flit
//   out_data   per-output flit, same packing as in_data
//   out_ready  downstream takes output p this cycle
//
// Flit header: dest X = data[COORD_W-1:0], dest Y = data[2*COORD_W-1:COORD_W]; flits pass unmodified.
module noc_router_rr #(
  parameter int XCOORD     = 0,
  parameter int YCOORD     = 0,
  parameter int COORD_W    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4:0]              in_valid,
  input  logic [5*DATA_WIDTH-1:0] in_data,
  output logic [4:0]              in_ready,
  output logic [4:0]              out_valid,
  output logic [5*DATA_WIDTH-1:0] out_data,
  input  logic [4:0]              out_ready
);

  localparam int NP    = 5;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [COORD_W-1:0] MY_X    = COORD_W'(XCOORD);
  localparam logic [COORD_W-1:0] MY_Y    = COORD_W'(YCOORD);

  localparam logic [2:0] PORT_N = 3'd0;
  localparam logic [2:0] PORT_S = 3'd1;
  localparam logic [2:0] PORT_E = 3'd2;
  localparam logic [2:0] PORT_W = 3'd3;
  localparam logic [2:0] PORT_L = 3'd4;

  // Input FIFO state
  logic [DATA_WIDTH-1:0] fifo_mem_r [NP][FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r   [NP];
  logic [PTR_W-1:0]      rd_ptr_r   [NP];
  logic [CNT_W-1:0]      count_r    [NP];

  // Output side state
  logic [2:0]            rr_r       [NP];
  logic [NP-1:0]         out_valid_r;
  logic [DATA_WIDTH-1:0] out_data_r [NP];

  // Combinational datapath
  logic [NP-1:0]         push_s;
  logic [NP-1:0]         pop_s;
  logic [NP-1:0]         nonempty_s;
  logic [DATA_WIDTH-1:0] head_s      [NP];
  logic [2:0]            route_s     [NP];
  logic [NP-1:0]         grant_vld_s;
  logic [2:0]            grant_idx_s [NP];

  // Dimension-order route: resolve X first, then Y, otherwise deliver locally.
  function automatic logic [2:0] route_of(input logic [DATA_WIDTH-1:0] flit);
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    logic [2:0]         port;
    dx = flit[COORD_W-1:0];
    dy = flit[2*COORD_W-1:COORD_W];
    if (dx > MY_X) begin
      port = PORT_E;
    end else if (dx < MY_X) begin
      port = PORT_W;
    end else if (dy > MY_Y) begin
      port = PORT_N;
    end else if (dy < MY_Y) begin
      port = PORT_S;
    end else begin
      port = PORT_L;
    end
    return port;
  endfunction

  // Ready depends on occupancy only, so a full FIFO refuses a flit even when it pops this cycle.
  always_comb begin
    in_ready = '0;
    for (int p = 0; p < NP; p++) begin
      in_ready[p] = !rst && (count_r[p] < DEPTH_C);
    end
  end

  // Per-input head flit, occupancy, route and write strobe.
  always_comb begin
    push_s     = '0;
    nonempty_s = '0;
    for (int p = 0; p < NP; p++) begin
      head_s[p]     = fifo_mem_r[p][rd_ptr_r[p]];
      nonempty_s[p] = (count_r[p] != '0);
      route_s[p]    = route_of(head_s[p]);
      push_s[p]     = in_valid[p] & in_ready[p];
    end
  end

  // Round-robin arbitration per output: first requester at or above rr, wrapping modulo 5.
  always_comb begin
    logic [3:0] cand;
    logic       hit;
    cand = 4'd0;
    hit  = 1'b0;
    for (int o = 0; o < NP; o++) begin
      grant_vld_s[o] = 1'b0;
      grant_idx_s[o] = 3'd0;
      for (int k = 0; k < NP; k++) begin
        cand = {1'b0, rr_r[o]} + 4'(k);
        cand = (cand >= 4'd5) ? (cand - 4'd5) : cand;
        // Only arbitrate when the output register is free this cycle.
        hit  = (!out_valid_r[o] || out_ready[o]) && !grant_vld_s[o] &&
               nonempty_s[cand[2:0]] && (route_s[cand[2:0]] == 3'(o));
        grant_vld_s[o] = grant_vld_s[o] | hit;
        grant_idx_s[o] = hit ? cand[2:0] : grant_idx_s[o];
      end
    end
  end

  // An input requests a single output, so at most one grant can pop it.
  always_comb begin
    pop_s = '0;
    for (int i = 0; i < NP; i++) begin
      for (int o = 0; o < NP; o++) begin
        pop_s[i] = pop_s[i] | (grant_vld_s[o] && (grant_idx_s[o] == 3'(i)));
      end
    end
  end

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (push_s[p]) begin
        fifo_mem_r[p][wr_ptr_r[p]] <= in_data[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (rst) begin
        wr_ptr_r[p] <= '0;
        rd_ptr_r[p] <= '0;
        count_r[p]  <= '0;
      end else begin
        wr_ptr_r[p] <= wr_ptr_r[p] + PTR_W'(push_s[p]);
        rd_ptr_r[p] <= rd_ptr_r[p] + PTR_W'(pop_s[p]);
        count_r[p]  <= count_r[p] + CNT_W'(push_s[p]) - CNT_W'(pop_s[p]);
      end
    end
  end

  // Output registers and round-robin pointers; a grant may load on the same edge as a transfer.
  always_ff @(posedge clk) begin
    for (int o = 0; o < NP; o++) begin
      if (rst) begin
        out_valid_r[o] <= 1'b0;
        out_data_r[o]  <= '0;
        rr_r[o]        <= 3'd0;
      end else if (grant_vld_s[o]) begin
        out_valid_r[o] <= 1'b1;
        out_data_r[o]  <= head_s[grant_idx_s[o]];
        rr_r[o]        <= (grant_idx_s[o] == 3'd4) ? 3'd0 : (grant_idx_s[o] + 3'd1);
      end else if (out_ready[o]) begin
        out_valid_r[o] <= 1'b0;
      end
    end
  end

  // Pack the output registers onto the port bus.
  always_comb begin
    out_data  = '0;
    out_valid = out_valid_r;
    for (int o = 0; o < NP; o++) begin
      out_data[o*DATA_WIDTH +: DATA_WIDTH] = out_data_r[o];
    end
  end

endmodule

// File: tb/tb_noc_router_rr.sv
// Directed testbench for noc_router_rr at node (2,2), COORD_W=4, DATA_WIDTH=32, FIFO_DEPTH=4.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_noc_router_rr;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    in_valid;
  logic [5*DW-1:0] in_data;
  logic [4:0]    in_ready;
  logic [4:0]    out_valid;
  logic [5*DW-1:0] out_data;
  logic [4:0]    out_ready;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  noc_router_rr #(
    .XCOORD    (2),
    .YCOORD    (2),
    .COORD_W   (4),
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vec_cnt++;
    if (obs !== exp_v) begin
      err_cnt++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] od(input int p);
    return out_data[p*DW +: DW];
  endfunction

  logic [31:0] rt_data [5] = '{32'h0000A123, 32'h0000A221, 32'h0000A332, 32'h0000A412, 32'h0000A522};
  int          rt_port [5] = '{2, 3, 0, 1, 4};
  logic [31:0] bp_flit [6] = '{32'h0000C123, 32'h0000C223, 32'h0000C323,
                               32'h0000C423, 32'h0000C523, 32'h0000C623};

  initial begin
    logic [4:0]  onehot;
    logic [31:0] ns_f;
    logic [31:0] ew_f;
    logic        acc;
    int          n;

    rst       = 1'b1;
    in_valid  = 5'h00;
    in_data   = '0;
    out_ready = 5'h1F;

    // Reset held three cycles
    step(); step(); step();
    check_val("rst_out_valid", {27'd0, out_valid}, 32'd0);
    check_val("rst_in_ready", {27'd0, in_ready}, 32'd0);
    for (int p = 0; p < 5; p++) check_val("rst_out_data", od(p), 32'd0);
    rst = 1'b0;
    step();
    check_val("rel_in_ready", {27'd0, in_ready}, 32'h1F);
    check_val("rel_out_valid", {27'd0, out_valid}, 32'd0);

    // Routing from the local port to every direction
    for (int k = 0; k < 5; k++) begin
      in_valid = 5'b10000;
      in_data[4*DW +: DW] = rt_data[k];
      step();
      in_valid = 5'h00;
      check_val("route_lat1", {27'd0, out_valid}, 32'd0);
      step();
      onehot = 5'b00001 << rt_port[k];
      check_val("route_valid", {27'd0, out_valid}, {27'd0, onehot});
      check_val("route_data", od(rt_port[k]), rt_data[k]);
      step();
    end

    // Contention: N, S, W, L all to East
    in_valid = 5'b11011;
    in_data = '0;
    in_data[0*DW +: DW] = 32'h0000B123;
    in_data[1*DW +: DW] = 32'h0000B223;
    in_data[3*DW +: DW] = 32'h0000B323;
    in_data[4*DW +: DW] = 32'h0000B423;
    step();
    in_valid = 5'h00;
    step();
    check_val("cont_v0", {31'd0, out_valid[2]}, 32'd1);
    check_val("cont_n", od(2), 32'h0000B123);
    step();
    check_val("cont_s", od(2), 32'h0000B223);
    step();
    check_val("cont_w", od(2), 32'h0000B323);
    step();
    check_val("cont_l", od(2), 32'h0000B423);
    step();
    check_val("cont_idle", {31'd0, out_valid[2]}, 32'd0);

    // rr[E] back at 0: West must beat Local
    in_valid = 5'b11000;
    in_data[3*DW +: DW] = 32'h0000B523;
    in_data[4*DW +: DW] = 32'h0000B623;
    step();
    in_valid = 5'h00;
    step();
    check_val("rr_first_w", od(2), 32'h0000B523);
    step();
    check_val("rr_then_l", od(2), 32'h0000B623);
    step();
    check_val("rr_idle", {31'd0, out_valid[2]}, 32'd0);

    // Backpressure: East stalled, West streams six flits
    in_data   = '0;
    out_ready = 5'b11011;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid[3] = (n < 6);
      in_data[3*DW +: DW] = bp_flit[(n < 6) ? n : 5];
      acc = in_valid[3] && in_ready[3];
      step();
      if (acc) n++;
    end
    check_val("bp_accepts", 32'(n), 32'd5);
    check_val("bp_in_ready_w", {31'd0, in_ready[3]}, 32'd0);
    check_val("bp_hold_valid", {31'd0, out_valid[2]}, 32'd1);
    check_val("bp_hold_data", od(2), bp_flit[0]);
    out_ready = 5'h1F;
    for (int k = 0; k < 6; k++) begin
      check_val("bp_drain_valid", {31'd0, out_valid[2]}, 32'd1);
      check_val("bp_drain_data", od(2), bp_flit[k]);
      in_valid[3] = (n < 6);
      in_data[3*DW +: DW] = bp_flit[(n < 6) ? n : 5];
      acc = in_valid[3] && in_ready[3];
      step();
      if (acc) n++;
    end
    in_valid = 5'h00;
    check_val("bp_total", 32'(n), 32'd6);
    check_val("bp_idle", {31'd0, out_valid[2]}, 32'd0);

    // Parallel N->S and E->W streams
    for (int t = 0; t < 10; t++) begin
      if (t >= 2) begin
        ns_f = 32'h0000D012 | (32'(t - 2) << 8);
        ew_f = 32'h0000E021 | (32'(t - 2) << 8);
        check_val("par_s_valid", {31'd0, out_valid[1]}, 32'd1);
        check_val("par_s_data", od(1), ns_f);
        check_val("par_w_valid", {31'd0, out_valid[3]}, 32'd1);
        check_val("par_w_data", od(3), ew_f);
      end
      if (t < 8) begin
        check_val("par_ready", {30'd0, in_ready[2], in_ready[0]}, 32'd3);
        in_valid = 5'b00101;
        in_data[0*DW +: DW] = 32'h0000D012 | (32'(t) << 8);
        in_data[2*DW +: DW] = 32'h0000E021 | (32'(t) << 8);
      end else begin
        in_valid = 5'h00;
      end
      step();
    end
    check_val("par_idle", {27'd0, out_valid}, 32'd0);

    // Reset mid-operation with flits buffered
    in_data   = '0;
    out_ready = 5'b11011;
    for (int k = 0; k < 4; k++) begin
      in_valid = 5'b01000;
      in_data[3*DW +: DW] = 32'h0000F123 | (32'(k) << 8);
      step();
    end
    in_valid = 5'h00;
    check_val("mid_pre_valid", {31'd0, out_valid[2]}, 32'd1);
    check_val("mid_pre_data", od(2), 32'h0000F123);
    rst = 1'b1;
    #1;
    check_val("mid_rst_in_ready", {27'd0, in_ready}, 32'd0);
    step(); step();
    check_val("mid_rst_valid", {27'd0, out_valid}, 32'd0);
    check_val("mid_rst_data", od(2), 32'd0);
    rst = 1'b0;
    step();
    check_val("mid_rel_in_ready", {27'd0, in_ready}, 32'h1F);
    out_ready = 5'h1F;
    for (int c = 0; c < 8; c++) begin
      check_val("mid_no_stale", {27'd0, out_valid}, 32'd0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
